id_pipe: RTL and testbench
==========================

// Module: id_pipe
// PURPOSE
//  Registered RV32I decode stage with a valid/ready handshake and a FIFO_DEPTH-entry decoded-instruction buffer.
//  Sits between the if_id register and ex. Absorbs ex back-pressure, supports flush on redirect and flags illegal encodings.
//  Adds over the combinational decoder: full immediate formats (I/S/B/U/J), rs1/rs2/rd enables and an optional CSR mode.
// PARAMETERS
//  ADDR_W      32  PC width
//  FIFO_DEPTH  2   decoded entries buffered; power of 2, >=1
//  EN_CSR      1   1: Zicsr decoded; 0: opcode 7'b1110011 with funct3!=0 is illegal
// PORTS
//  clk             in   1       clock, rising edge
//  rst_n           in   1       synchronous reset, ACTIVE-HIGH (1 = reset)
//  flush_i         in   1       discard all buffered entries and this cycle's push
//  in_valid_i      in   1       instruction offered
//  in_ready_o      in/o out 1   stage can accept
//  in_pc_i         in   ADDR_W  PC of offered instruction
//  in_inst_i       in   32      raw instruction
//  out_valid_o     out  1       head entry valid
//  out_ready_i     in   1       ex consumes head
//  out_pc_o        out  ADDR_W  head PC
//  out_opcode_o    out  7       inst[6:0]
//  out_funct3_o    out  3       inst[14:12]; 0 for LUI/AUIPC/JAL
//  out_funct7_o    out  7       inst[31:25] for OP/shift-imm, else 0
//  out_rd_o        out  5       rd address
//  out_rs1_o       out  5       rs1 address
//  out_rs2_o       out  5       rs2 address
//  out_rd_we_o     out  1       writes rd (0 if rd==x0)
//  out_rs1_en_o    out  1       reads rs1
//  out_rs2_en_o    out  1       reads rs2
//  out_imm_o       out  32      formatted immediate
//  out_csr_addr_o  out  12      inst[31:20] for CSR ops, else 0
//  out_illegal_o   out  1       illegal encoding; ex raises exception
// BEHAVIOUR
//  Reset (rst_n=1): count/pointers 0; out_valid_o=0; in_ready_o=0 while asserted; all out_* data = 0.
//  in_ready_o = !rst_n_active && (count != FIFO_DEPTH). No full-bypass: push when full is blocked even if popping.
//  Push = in_valid_i & in_ready_o & !flush_i: decode in_inst_i combinationally, write entry at wr_ptr.
//  Pop = out_valid_o & out_ready_i. Push+pop same cycle: count unchanged. Pointers wrap modulo FIFO_DEPTH.
//  Latency: accepted in cycle N -> visible on out_* in cycle N+1 if the buffer was empty.
//  out_valid_o = (count != 0). out_* show head entry; they hold stable while out_valid_o & !out_ready_i.
//  When empty, out_* data = 0.
//  flush_i: next cycle count=0, out_valid_o=0. Flush beats push and pop in the same cycle. Reset beats flush.
//  Immediates: I = sext(inst[31:20]); S = sext({inst[31:25],inst[11:7]}); B = sext({inst[31],inst[7],inst[30:25],inst[11:8],0}).
//  Immediates: U = {inst[31:12],12'h0}; J = sext({inst[31],inst[19:12],inst[20],inst[30:21],0}).
//  Immediates: shift-imm = {27'h0,inst[24:20]}; CSRxI = {27'h0,inst[19:15]} (zimm); R/fence = 0.
//  Enables: rs1_en for I/L/S/B/R/JALR/CSR(reg); rs2_en for S/B/R; rd_we for all but S/B/FENCE/SYSTEM-priv, and never for rd=0.
//  Illegal: inst[1:0]!=2'b11; unknown opcode; JALR funct3!=0; load funct3 in {011,110,111}; store funct3>=011.
//  Illegal: branch funct3 in {010,011}; SLLI funct7!=0; SRLI/SRAI funct7 not in {0x00,0x20}.
//  Illegal: OP funct7 not 0x00 (or 0x20 for ADD/SUB, SRL/SRA); SYSTEM funct3=100.
//  Illegal: SYSTEM funct3=000 other than ECALL 0x00000073 / EBREAK 0x00100073 / MRET 0x30200073.
//  Illegal entry: pc and opcode kept; all enables 0, imm 0, out_illegal_o=1. It still flows through the FIFO in order.
// TESTING
//  1 Reset 3 cycles, then release -> in_ready_o=1, out_valid_o=0, all out_* 0.
//  2 Push 0xFFF00093 (addi x1,x0,-1) at pc 0x100 -> next cycle: rd=1, rs1=0, rs1_en=1, rd_we=1, imm=0xFFFFFFFF, illegal=0.
//  3 out_ready_i=0; push 0x008000EF, 0x00208463, 0x00000013 -> in_ready_o=0 after 2 pushes, head imm=8.
//    Then ready=1 -> pops in order; BEQ shows imm=8, rs2_en=1, rd_we=0.
//  4 FIFO holds 2 entries; flush_i=1 with in_valid_i=1 -> next cycle out_valid_o=0, count 0, pushed entry lost.
//  5 Push 0x00000000 and 0x40001013 -> both out_illegal_o=1 with all enables 0; 0x40005013 (srai) legal, imm=0.
//  6 EN_CSR=0: push 0x30001073 -> illegal; EN_CSR=1: same -> csr_addr=0x300, rs1_en=1. Reset mid-stream -> FIFO empties next cycle.

Source files
------------

// File: rtl/id_pipe.sv
// rtl/id_pipe.sv - Registered RV32I decode stage with valid/ready handshake and decoded-entry buffer
module id_pipe #(
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 2,
    parameter bit EN_CSR     = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [ADDR_W-1:0] in_pc_i,
    input  logic [31:0]       in_inst_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_pc_o,
    output logic [6:0]        out_opcode_o,
    output logic [2:0]        out_funct3_o,
    output logic [6:0]        out_funct7_o,
    output logic [4:0]        out_rd_o,
    output logic [4:0]        out_rs1_o,
    output logic [4:0]        out_rs2_o,
    output logic              out_rd_we_o,
    output logic              out_rs1_en_o,
    output logic              out_rs2_en_o,
    output logic [31:0]       out_imm_o,
    output logic [11:0]       out_csr_addr_o,
    output logic              out_illegal_o
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic              rd_we;
        logic              rs1_en;
        logic              rs2_en;
        logic [31:0]       imm;
        logic [11:0]       csr_addr;
        logic              illegal;
    } entry_t;

    logic [31:0] inst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd_f;
    logic [4:0]  rs1_f;
    logic [4:0]  rs2_f;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm_sh;
    logic [31:0] imm_z;

    assign inst   = in_inst_i;
    assign op     = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    assign rd_f   = inst[11:7];
    assign rs1_f  = inst[19:15];
    assign rs2_f  = inst[24:20];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'h000};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_sh = {27'h0, inst[24:20]};
    assign imm_z  = {27'h0, inst[19:15]};

    entry_t dec;
    logic   bad;

    always_comb begin
        dec        = '0;
        bad        = 1'b0;
        dec.pc     = in_pc_i;
        dec.opcode = op;
        dec.funct3 = f3;
        dec.rd     = rd_f;
        dec.rs1    = rs1_f;
        dec.rs2    = rs2_f;
        case (op)
            OP_LUI, OP_AUIPC: begin
                dec.funct3 = 3'b000;
                dec.imm    = imm_u;
                dec.rd_we  = 1'b1;
            end
            OP_JAL: begin
                dec.funct3 = 3'b000;
                dec.imm    = imm_j;
                dec.rd_we  = 1'b1;
            end
            OP_JALR: begin
                dec.imm    = imm_i;
                dec.rs1_en = 1'b1;
                dec.rd_we  = 1'b1;
                bad        = (f3 != 3'b000);
            end
            OP_BRANCH: begin
                dec.imm    = imm_b;
                dec.rs1_en = 1'b1;
                dec.rs2_en = 1'b1;
                bad        = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OP_LOAD: begin
                dec.imm    = imm_i;
                dec.rs1_en = 1'b1;
                dec.rd_we  = 1'b1;
                bad        = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OP_STORE: begin
                dec.imm    = imm_s;
                dec.rs1_en = 1'b1;
                dec.rs2_en = 1'b1;
                bad        = (f3 >= 3'b011);
            end
            OP_IMM: begin
                dec.rs1_en = 1'b1;
                dec.rd_we  = 1'b1;
                if (f3 == 3'b001) begin
                    dec.funct7 = f7;
                    dec.imm    = imm_sh;
                    bad        = (f7 != 7'h00);
                end else if (f3 == 3'b101) begin
                    dec.funct7 = f7;
                    dec.imm    = imm_sh;
                    bad        = (f7 != 7'h00) && (f7 != 7'h20);
                end else begin
                    dec.imm    = imm_i;
                end
            end
            OP_OP: begin
                dec.funct7 = f7;
                dec.rs1_en = 1'b1;
                dec.rs2_en = 1'b1;
                dec.rd_we  = 1'b1;
                bad        = !((f7 == 7'h00) ||
                               ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OP_FENCE: begin
                dec.imm = '0;
            end
            OP_SYSTEM: begin
                if (f3 == 3'b000) begin
                    // Only the three privileged encodings exist; anything else under funct3=0 traps
                    bad = !((inst == 32'h00000073) || (inst == 32'h00100073) ||
                            (inst == 32'h30200073));
                end else if ((f3 == 3'b100) || !EN_CSR) begin
                    bad = 1'b1;
                end else begin
                    dec.csr_addr = inst[31:20];
                    dec.rd_we    = 1'b1;
                    if (f3[2]) dec.imm    = imm_z;
                    else       dec.rs1_en = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase
        if (inst[1:0] != 2'b11) bad = 1'b1;
        dec.rd_we = dec.rd_we && (rd_f != 5'd0);
        if (bad) begin
            dec         = '0;
            dec.pc      = in_pc_i;
            dec.opcode  = op;
            dec.illegal = 1'b1;
        end
    end

    entry_t          mem [FIFO_DEPTH];
    logic [CW-1:0]   count;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    entry_t          head;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign in_ready_o  = !rst_n && (count != FULL);
    assign out_valid_o = (count != '0);
    assign push        = in_valid_i && in_ready_o && !flush_i;
    assign pop         = out_valid_o && out_ready_i;

    always_ff @(posedge clk) begin
        if (rst_n || flush_i) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    // Storage is never cleared; gating on occupancy keeps empty outputs at zero
    assign head = out_valid_o ? mem[rd_ptr] : '0;

    assign out_pc_o       = head.pc;
    assign out_opcode_o   = head.opcode;
    assign out_funct3_o   = head.funct3;
    assign out_funct7_o   = head.funct7;
    assign out_rd_o       = head.rd;
    assign out_rs1_o      = head.rs1;
    assign out_rs2_o      = head.rs2;
    assign out_rd_we_o    = head.rd_we;
    assign out_rs1_en_o   = head.rs1_en;
    assign out_rs2_en_o   = head.rs2_en;
    assign out_imm_o      = head.imm;
    assign out_csr_addr_o = head.csr_addr;
    assign out_illegal_o  = head.illegal;

endmodule

// File: tb/tb_id_pipe.sv
// tb/tb_id_pipe.sv - Directed self-checking bench for id_pipe
module tb_id_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        in_valid_i;
    logic [31:0] in_pc_i;
    logic [31:0] in_inst_i;
    logic        out_ready_i;

    logic        in_ready_o, out_valid_o, out_rd_we_o, out_rs1_en_o, out_rs2_en_o, out_illegal_o;
    logic [31:0] out_pc_o, out_imm_o;
    logic [6:0]  out_opcode_o, out_funct7_o;
    logic [2:0]  out_funct3_o;
    logic [4:0]  out_rd_o, out_rs1_o, out_rs2_o;
    logic [11:0] out_csr_addr_o;

    logic        n_in_ready, n_out_valid, n_rd_we, n_rs1_en, n_rs2_en, n_illegal;
    logic [31:0] n_pc, n_imm;
    logic [6:0]  n_opcode, n_funct7;
    logic [2:0]  n_funct3;
    logic [4:0]  n_rd, n_rs1, n_rs2;
    logic [11:0] n_csr_addr;

    int checks = 0;
    int fails  = 0;

    id_pipe #(.ADDR_W(32), .FIFO_DEPTH(2), .EN_CSR(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_pc_i(in_pc_i), .in_inst_i(in_inst_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pc_o(out_pc_o),
        .out_opcode_o(out_opcode_o), .out_funct3_o(out_funct3_o), .out_funct7_o(out_funct7_o),
        .out_rd_o(out_rd_o), .out_rs1_o(out_rs1_o), .out_rs2_o(out_rs2_o),
        .out_rd_we_o(out_rd_we_o), .out_rs1_en_o(out_rs1_en_o), .out_rs2_en_o(out_rs2_en_o),
        .out_imm_o(out_imm_o), .out_csr_addr_o(out_csr_addr_o), .out_illegal_o(out_illegal_o)
    );

    id_pipe #(.ADDR_W(32), .FIFO_DEPTH(2), .EN_CSR(1'b0)) u_dut_nocsr (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(n_in_ready), .in_pc_i(in_pc_i), .in_inst_i(in_inst_i),
        .out_valid_o(n_out_valid), .out_ready_i(out_ready_i), .out_pc_o(n_pc),
        .out_opcode_o(n_opcode), .out_funct3_o(n_funct3), .out_funct7_o(n_funct7),
        .out_rd_o(n_rd), .out_rs1_o(n_rs1), .out_rs2_o(n_rs2),
        .out_rd_we_o(n_rd_we), .out_rs1_en_o(n_rs1_en), .out_rs2_en_o(n_rs2_en),
        .out_imm_o(n_imm), .out_csr_addr_o(n_csr_addr), .out_illegal_o(n_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] inst);
        in_valid_i = 1'b1;
        in_pc_i    = pc;
        in_inst_i  = inst;
        step();
        in_valid_i = 1'b0;
    endtask

    task automatic pop_one();
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        step(); step(); step();
        checks++; if (in_ready_o !== 1'b0) begin fails++; $display("FAIL rst_ready_held: got %0h want 0", in_ready_o); end
        checks++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL rst_valid_held: got %0h want 0", out_valid_o); end
        rst_n = 1'b0;
        step();
        checks++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL rst_ready: got %0h want 1", in_ready_o); end
        checks++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0h want 0", out_valid_o); end
        checks++; if ({out_pc_o, out_imm_o, out_opcode_o, out_rd_o, out_csr_addr_o, out_illegal_o, out_rd_we_o} !== '0)
            begin fails++; $display("FAIL rst_data: pc %h imm %h op %h", out_pc_o, out_imm_o, out_opcode_o); end
    endtask

    task automatic test_addi();
        push_one(32'h100, 32'hFFF00093);
        checks++; if (out_valid_o !== 1'b1) begin fails++; $display("FAIL addi_valid: got %0h want 1", out_valid_o); end
        checks++; if (out_pc_o !== 32'h100) begin fails++; $display("FAIL addi_pc: got %h want 100", out_pc_o); end
        checks++; if (out_rd_o !== 5'd1) begin fails++; $display("FAIL addi_rd: got %0d want 1", out_rd_o); end
        checks++; if (out_rs1_o !== 5'd0) begin fails++; $display("FAIL addi_rs1: got %0d want 0", out_rs1_o); end
        checks++; if ({out_rs1_en_o, out_rs2_en_o, out_rd_we_o} !== 3'b101) begin fails++; $display("FAIL addi_en: got %b want 101", {out_rs1_en_o, out_rs2_en_o, out_rd_we_o}); end
        checks++; if (out_imm_o !== 32'hFFFFFFFF) begin fails++; $display("FAIL addi_imm: got %h want ffffffff", out_imm_o); end
        checks++; if (out_illegal_o !== 1'b0) begin fails++; $display("FAIL addi_illegal: got %0h want 0", out_illegal_o); end
        checks++; if ({out_opcode_o, out_funct3_o, out_funct7_o} !== {7'h13, 3'd0, 7'h00}) begin fails++; $display("FAIL addi_fields: op %h f3 %h f7 %h", out_opcode_o, out_funct3_o, out_funct7_o); end
        pop_one();
        checks++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL addi_drain: got %0h want 0", out_valid_o); end
    endtask

    task automatic test_back_to_back();
        out_ready_i = 1'b0;
        push_one(32'h200, 32'h008000EF);
        checks++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL b2b_ready1: got %0h want 1", in_ready_o); end
        push_one(32'h204, 32'h00208463);
        checks++; if (in_ready_o !== 1'b0) begin fails++; $display("FAIL b2b_full: got %0h want 0", in_ready_o); end
        push_one(32'h208, 32'h00000013);
        checks++; if (out_pc_o !== 32'h200) begin fails++; $display("FAIL b2b_head_pc: got %h want 200", out_pc_o); end
        checks++; if (out_imm_o !== 32'h8) begin fails++; $display("FAIL b2b_jal_imm: got %h want 8", out_imm_o); end
        checks++; if ({out_rd_o, out_rd_we_o, out_funct3_o} !== {5'd1, 1'b1, 3'd0}) begin fails++; $display("FAIL b2b_jal_rd: rd %0d we %0d f3 %0d", out_rd_o, out_rd_we_o, out_funct3_o); end
        // Full: push blocked while popping, so the NOP only lands on the next edge
        in_valid_i = 1'b1; out_ready_i = 1'b1;
        step();
        checks++; if (out_pc_o !== 32'h204) begin fails++; $display("FAIL b2b_beq_pc: got %h want 204", out_pc_o); end
        checks++; if (out_imm_o !== 32'h8) begin fails++; $display("FAIL b2b_beq_imm: got %h want 8", out_imm_o); end
        checks++; if ({out_rs1_en_o, out_rs2_en_o, out_rd_we_o} !== 3'b110) begin fails++; $display("FAIL b2b_beq_en: got %b want 110", {out_rs1_en_o, out_rs2_en_o, out_rd_we_o}); end
        checks++; if ({out_rs1_o, out_rs2_o} !== {5'd1, 5'd2}) begin fails++; $display("FAIL b2b_beq_rs: rs1 %0d rs2 %0d want 1 2", out_rs1_o, out_rs2_o); end
        step();
        in_valid_i = 1'b0;
        checks++; if (out_pc_o !== 32'h208) begin fails++; $display("FAIL b2b_nop_pc: got %h want 208", out_pc_o); end
        checks++; if ({out_rd_we_o, out_rs1_en_o, out_imm_o} !== {1'b0, 1'b1, 32'h0}) begin fails++; $display("FAIL b2b_nop: we %0d rs1en %0d imm %h", out_rd_we_o, out_rs1_en_o, out_imm_o); end
        step();
        out_ready_i = 1'b0;
        checks++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL b2b_empty: got %0h want 0", out_valid_o); end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        push_one(32'h300, 32'h00100093);
        push_one(32'h304, 32'h00200113);
        checks++; if ({out_valid_o, in_ready_o, out_pc_o} !== {1'b1, 1'b0, 32'h300}) begin fails++; $display("FAIL flush_pre: v %0d r %0d pc %h", out_valid_o, in_ready_o, out_pc_o); end
        flush_i = 1'b1; in_valid_i = 1'b1; in_pc_i = 32'h308; in_inst_i = 32'h00300193;
        step();
        flush_i = 1'b0; in_valid_i = 1'b0;
        checks++; if ({out_valid_o, in_ready_o, out_pc_o} !== {1'b0, 1'b1, 32'h0}) begin fails++; $display("FAIL flush_full: v %0d r %0d pc %h", out_valid_o, in_ready_o, out_pc_o); end
        push_one(32'h30C, 32'h00100093);
        flush_i = 1'b1; in_valid_i = 1'b1; in_pc_i = 32'h310; in_inst_i = 32'h00300193;
        step();
        flush_i = 1'b0; in_valid_i = 1'b0;
        checks++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL flush_push_lost: got %0h want 0", out_valid_o); end
        push_one(32'h314, 32'h00500293);
        checks++; if ({out_pc_o, out_rd_o, out_imm_o} !== {32'h314, 5'd5, 32'h5}) begin fails++; $display("FAIL flush_after: pc %h rd %0d imm %h", out_pc_o, out_rd_o, out_imm_o); end
        pop_one();
    endtask

    task automatic test_illegal();
        out_ready_i = 1'b0;
        push_one(32'h400, 32'h00000000);
        checks++; if ({out_illegal_o, out_pc_o, out_opcode_o} !== {1'b1, 32'h400, 7'h00}) begin fails++; $display("FAIL ill_zero: ill %0d pc %h op %h", out_illegal_o, out_pc_o, out_opcode_o); end
        checks++; if ({out_rd_we_o, out_rs1_en_o, out_rs2_en_o, out_imm_o} !== '0) begin fails++; $display("FAIL ill_zero_en: en %b imm %h", {out_rd_we_o, out_rs1_en_o, out_rs2_en_o}, out_imm_o); end
        pop_one();
        push_one(32'h404, 32'h40001013);
        checks++; if ({out_illegal_o, out_opcode_o, out_funct7_o} !== {1'b1, 7'h13, 7'h00}) begin fails++; $display("FAIL ill_slli: ill %0d op %h f7 %h", out_illegal_o, out_opcode_o, out_funct7_o); end
        checks++; if ({out_rd_we_o, out_rs1_en_o, out_rs2_en_o} !== 3'b000) begin fails++; $display("FAIL ill_slli_en: got %b want 000", {out_rd_we_o, out_rs1_en_o, out_rs2_en_o}); end
        pop_one();
        push_one(32'h408, 32'h40005013);
        checks++; if ({out_illegal_o, out_imm_o, out_funct7_o, out_rs1_en_o} !== {1'b0, 32'h0, 7'h20, 1'b1}) begin fails++; $display("FAIL srai: ill %0d imm %h f7 %h", out_illegal_o, out_imm_o, out_funct7_o); end
        pop_one();
        push_one(32'h40C, 32'h00309093);
        checks++; if ({out_illegal_o, out_imm_o, out_rd_we_o} !== {1'b0, 32'h3, 1'b1}) begin fails++; $display("FAIL slli3: ill %0d imm %h we %0d", out_illegal_o, out_imm_o, out_rd_we_o); end
        pop_one();
        push_one(32'h410, 32'hFE20AE23);
        checks++; if ({out_imm_o, out_rs2_en_o, out_rd_we_o, out_illegal_o} !== {32'hFFFFFFFC, 1'b1, 1'b0, 1'b0}) begin fails++; $display("FAIL sw: imm %h rs2en %0d we %0d", out_imm_o, out_rs2_en_o, out_rd_we_o); end
        pop_one();
        push_one(32'h414, 32'h123452B7);
        checks++; if ({out_imm_o, out_rd_o, out_funct3_o, out_rs1_en_o} !== {32'h12345000, 5'd5, 3'd0, 1'b0}) begin fails++; $display("FAIL lui: imm %h rd %0d f3 %0d", out_imm_o, out_rd_o, out_funct3_o); end
        pop_one();
    endtask

    task automatic test_csr_and_reset();
        out_ready_i = 1'b0;
        push_one(32'h600, 32'h30001073);
        checks++; if ({out_illegal_o, out_csr_addr_o, out_rs1_en_o, out_rd_we_o} !== {1'b0, 12'h300, 1'b1, 1'b0}) begin fails++; $display("FAIL csrrw: ill %0d csr %h rs1en %0d", out_illegal_o, out_csr_addr_o, out_rs1_en_o); end
        checks++; if ({n_illegal, n_csr_addr, n_rs1_en, n_pc} !== {1'b1, 12'h000, 1'b0, 32'h600}) begin fails++; $display("FAIL csrrw_nocsr: ill %0d csr %h pc %h", n_illegal, n_csr_addr, n_pc); end
        pop_one();
        push_one(32'h604, 32'h3052E1F3);
        checks++; if ({out_imm_o, out_csr_addr_o, out_rs1_en_o, out_rd_we_o} !== {32'h5, 12'h305, 1'b0, 1'b1}) begin fails++; $display("FAIL csrrsi: imm %h csr %h rs1en %0d we %0d", out_imm_o, out_csr_addr_o, out_rs1_en_o, out_rd_we_o); end
        pop_one();
        push_one(32'h608, 32'h00000073);
        checks++; if ({out_illegal_o, n_illegal, out_rd_we_o} !== 3'b000) begin fails++; $display("FAIL ecall: ill %0d nill %0d we %0d", out_illegal_o, n_illegal, out_rd_we_o); end
        pop_one();
        push_one(32'h60C, 32'h00000173);
        checks++; if (out_illegal_o !== 1'b1) begin fails++; $display("FAIL sys_bad: got %0h want 1", out_illegal_o); end
        pop_one();
        push_one(32'h610, 32'h00004073);
        checks++; if (out_illegal_o !== 1'b1) begin fails++; $display("FAIL sys_f3_4: got %0h want 1", out_illegal_o); end
        pop_one();
        push_one(32'h700, 32'h00100093);
        push_one(32'h704, 32'h00200113);
        rst_n = 1'b1;
        step();
        checks++; if ({out_valid_o, in_ready_o, out_pc_o} !== {1'b0, 1'b0, 32'h0}) begin fails++; $display("FAIL midrst: v %0d r %0d pc %h", out_valid_o, in_ready_o, out_pc_o); end
        rst_n = 1'b0;
        step();
        checks++; if ({out_valid_o, in_ready_o} !== 2'b01) begin fails++; $display("FAIL midrst_release: v %0d r %0d", out_valid_o, in_ready_o); end
    endtask

    initial begin
        rst_n = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0;
        in_pc_i = '0; in_inst_i = '0; out_ready_i = 1'b0;
        test_reset();
        test_addi();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_csr_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
